// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;
    localparam logic [31:0]           CNT_MAX    = 32'hFFFF_FFFF;

    // Increment-by-one that holds at CNT_MAX instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: load in EX whose destination is a source of the instruction in ID.
// Latency: purely combinational.
// Backpressure: none; the result feeds the controller's stall decision.
import pipe_ctrl_pkg::*;

module hazard_detect (
    input  logic [REG_ADDR_W-1:0] if_id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] if_id_rt_addr_i,
    input  logic                  id_ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rt_addr_i,
    output logic                  load_use_o
);

    // Register zero is never a real dependency, so a load targeting it cannot stall.
    always_comb begin
        load_use_o = id_ex_mem_read_i
                   && (id_ex_rt_addr_i != REG_ZERO)
                   && ((id_ex_rt_addr_i == if_id_rs_addr_i) || (id_ex_rt_addr_i == if_id_rt_addr_i));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with memory watchdog; optional perf counters (PERF_CNT_EN).
// Latency: controls are combinational from registered FSM state and current inputs (zero added cycles).
// Backpressure: a pending data-memory access freezes all stage registers until dmem_ack_i; timeout parks in ERROR.
import pipe_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RSaddr_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RTaddr_i,
    input  logic                  ID_EX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] ID_EX_RTaddr_i,
    input  logic                  Branch_taken_i,
    input  logic                  EX_MEM_MemRead_i,
    input  logic                  EX_MEM_MemWrite_i,
    input  logic                  dmem_ack_i,
    output logic                  dmem_req_o,
    output logic                  PC_we_o,
    output logic                  IF_ID_we_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_we_o,
    output logic                  ID_EX_bubble_o,
    output logic                  EX_MEM_we_o,
    output logic                  MEM_WB_bubble_o,
    output logic                  error_o,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           flush_count_o
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              load_use;
    logic              mem_access;
    logic              mem_stall;

    hazard_detect u_hazard (
        .if_id_rs_addr_i  (IF_ID_RSaddr_i),
        .if_id_rt_addr_i  (IF_ID_RTaddr_i),
        .id_ex_mem_read_i (ID_EX_MemRead_i),
        .id_ex_rt_addr_i  (ID_EX_RTaddr_i),
        .load_use_o       (load_use)
    );

    // FSM state and watchdog counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state, watchdog and stage controls, resolved by priority: reset, ERROR, memory stall, load-use, branch.
    always_comb begin
        state_d         = state_q;
        wcnt_d          = wcnt_q;
        mem_access      = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;
        mem_stall       = 1'b0;
        dmem_req_o      = mem_access;
        PC_we_o         = 1'b1;
        IF_ID_we_o      = 1'b1;
        IF_ID_flush_o   = 1'b0;
        ID_EX_we_o      = 1'b1;
        ID_EX_bubble_o  = 1'b0;
        EX_MEM_we_o     = 1'b1;
        MEM_WB_bubble_o = 1'b0;
        error_o         = 1'b0;

        if (rst_i) begin
            // Hold every stage and fill with NOPs while reset is held.
            dmem_req_o      = 1'b0;
            PC_we_o         = 1'b0;
            IF_ID_we_o      = 1'b0;
            ID_EX_we_o      = 1'b0;
            EX_MEM_we_o     = 1'b0;
            IF_ID_flush_o   = 1'b1;
            ID_EX_bubble_o  = 1'b1;
            MEM_WB_bubble_o = 1'b1;
        end else if (state_q == ERROR) begin
            dmem_req_o  = 1'b0;
            PC_we_o     = 1'b0;
            IF_ID_we_o  = 1'b0;
            ID_EX_we_o  = 1'b0;
            EX_MEM_we_o = 1'b0;
            error_o     = 1'b1;
        end else begin
            mem_stall = (state_q == MEM_WAIT) ? !dmem_ack_i : (mem_access && !dmem_ack_i);
            if (mem_stall) begin
                dmem_req_o      = 1'b1;
                PC_we_o         = 1'b0;
                IF_ID_we_o      = 1'b0;
                ID_EX_we_o      = 1'b0;
                EX_MEM_we_o     = 1'b0;
                MEM_WB_bubble_o = 1'b1;
                if (state_q == RUN) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = ERROR;
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end
            end else begin
                // Completion cycle of a waited access keeps the request visible.
                if (state_q == MEM_WAIT) begin
                    dmem_req_o = 1'b1;
                    state_d    = RUN;
                end
                if (load_use) begin
                    // A simultaneous taken branch is dropped; it re-resolves once the load clears.
                    PC_we_o        = 1'b0;
                    IF_ID_we_o     = 1'b0;
                    ID_EX_bubble_o = 1'b1;
                end else if (Branch_taken_i) begin
                    IF_ID_flush_o = 1'b1;
                end
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating counts of PC-stalled cycles and IF/ID flushes since reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= sat_inc(stall_cnt_q, !PC_we_o);
            flush_cnt_q <= sat_inc(flush_cnt_q, IF_ID_flush_o);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl built with TIMEOUT=4.
// Latency: inputs change on the falling edge, outputs are checked 1 ns later.
// Backpressure: memory ack is driven directly by the stimulus sequence.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
    logic        id_ex_rd, br, ex_rd, ex_wr, ack;
    logic        req, pc_we, ifid_we, ifid_flush, idex_we, idex_bub, exmem_we, memwb_bub, err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [8:0]  ctl;

    int cmp   = 0;
    int fails = 0;

    // {req, PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_bubble, EX_MEM_we, MEM_WB_bubble, error}
    localparam logic [8:0] V_RST   = 9'b0_0_0_1_0_1_0_1_0;
    localparam logic [8:0] V_NORM  = 9'b0_1_1_0_1_0_1_0_0;
    localparam logic [8:0] V_NREQ  = 9'b1_1_1_0_1_0_1_0_0;
    localparam logic [8:0] V_LU    = 9'b0_0_0_0_1_1_1_0_0;
    localparam logic [8:0] V_LUREQ = 9'b1_0_0_0_1_1_1_0_0;
    localparam logic [8:0] V_BR    = 9'b0_1_1_1_1_0_1_0_0;
    localparam logic [8:0] V_MST   = 9'b1_0_0_0_0_0_0_1_0;
    localparam logic [8:0] V_ERR   = 9'b0_0_0_0_0_0_0_0_1;

`ifdef PERF_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
    localparam logic [31:0] EXP_FLUSH = 32'd1;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(4)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .IF_ID_RSaddr_i    (if_id_rs),
        .IF_ID_RTaddr_i    (if_id_rt),
        .ID_EX_MemRead_i   (id_ex_rd),
        .ID_EX_RTaddr_i    (id_ex_rt),
        .Branch_taken_i    (br),
        .EX_MEM_MemRead_i  (ex_rd),
        .EX_MEM_MemWrite_i (ex_wr),
        .dmem_ack_i        (ack),
        .dmem_req_o        (req),
        .PC_we_o           (pc_we),
        .IF_ID_we_o        (ifid_we),
        .IF_ID_flush_o     (ifid_flush),
        .ID_EX_we_o        (idex_we),
        .ID_EX_bubble_o    (idex_bub),
        .EX_MEM_we_o       (exmem_we),
        .MEM_WB_bubble_o   (memwb_bub),
        .error_o           (err),
        .stall_cycles_o    (stall_cnt),
        .flush_count_o     (flush_cnt)
    );

    assign ctl = {req, pc_we, ifid_we, ifid_flush, idex_we, idex_bub, exmem_we, memwb_bub, err};

    // Check this cycle's control vector, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic [8:0] exp);
        #1;
        cmp++;
        assert (ctl === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, ctl, exp);
        end
        @(negedge clk);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if_id_rs = 5'd0; if_id_rt = 5'd0; id_ex_rt = 5'd0;
        id_ex_rd = 1'b0; br = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0; ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        cyc("reset_outputs", V_RST);
        rst = 1'b0;
        #1;
        chk32("stall_after_reset", stall_cnt, 32'd0);
        chk32("flush_after_reset", flush_cnt, 32'd0);
        cyc("run_after_reset", V_NORM);

        // Load-use via rs, then via rt, each for exactly one cycle.
        id_ex_rd = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
        cyc("load_use_rs", V_LU);
        idle();
        cyc("load_use_rs_clear", V_NORM);
        id_ex_rd = 1'b1; id_ex_rt = 5'd5; if_id_rt = 5'd5; if_id_rs = 5'd3;
        cyc("load_use_rt", V_LU);
        // Load to r0 matching r0 sources is not a hazard.
        id_ex_rd = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
        cyc("load_r0_no_stall", V_NORM);
        idle();
        br = 1'b1;
        cyc("branch_flush", V_BR);
        idle();

        // Load with ack three cycles later.
        ex_rd = 1'b1;
        cyc("mem_wait_1", V_MST);
        cyc("mem_wait_2", V_MST);
        cyc("mem_wait_3", V_MST);
        ack = 1'b1;
        cyc("mem_ack", V_NREQ);
        idle();
        #1;
        chk32("stall_cycles", stall_cnt, EXP_STALL);
        chk32("flush_count", flush_cnt, EXP_FLUSH);
        cyc("mem_back_to_run", V_NORM);

        // Branch together with load-use: stall wins, branch re-resolves next cycle.
        id_ex_rd = 1'b1; id_ex_rt = 5'd9; if_id_rs = 5'd9; br = 1'b1;
        cyc("branch_vs_load_use", V_LU);
        idle();
        br = 1'b1;
        cyc("branch_after_load_use", V_BR);
        idle();
        cyc("branch_one_cycle", V_NORM);

        // Memory stall masks load-use; load-use applies on the ack cycle.
        ex_wr = 1'b1; id_ex_rd = 1'b1; id_ex_rt = 5'd4; if_id_rs = 5'd4;
        cyc("mem_stall_masks_lu", V_MST);
        ack = 1'b1;
        cyc("ack_with_load_use", V_LUREQ);
        idle();
        cyc("after_ack_lu", V_NORM);

        // Zero-wait access: no stall, no state change.
        ex_wr = 1'b1; ack = 1'b1;
        cyc("zero_wait", V_NREQ);
        idle();
        cyc("zero_wait_next", V_NORM);

        // Ack on the last allowed wait cycle beats the watchdog.
        ex_rd = 1'b1;
        cyc("edge_run", V_MST);
        cyc("edge_w0", V_MST);
        cyc("edge_w1", V_MST);
        cyc("edge_w2", V_MST);
        ack = 1'b1;
        cyc("edge_ack_wins", V_NREQ);
        idle();
        cyc("edge_back_run", V_NORM);

        // Store never acknowledged: ERROR after 1+4 stalled cycles, and it stays there.
        ex_wr = 1'b1;
        cyc("to_run", V_MST);
        cyc("to_w0", V_MST);
        cyc("to_w1", V_MST);
        cyc("to_w2", V_MST);
        cyc("to_w3", V_MST);
        cyc("error_entered", V_ERR);
        ack = 1'b1; br = 1'b1; id_ex_rd = 1'b1; id_ex_rt = 5'd7; if_id_rs = 5'd7;
        cyc("error_sticky", V_ERR);
        idle();
        rst = 1'b1;
        cyc("reset_in_error", V_RST);
        rst = 1'b0;
        #1;
        chk32("stall_after_reset2", stall_cnt, 32'd0);
        cyc("error_cleared", V_NORM);

        // Reset in the middle of a memory wait aborts the access.
        ex_rd = 1'b1;
        cyc("mid_run", V_MST);
        cyc("mid_w0", V_MST);
        rst = 1'b1;
        cyc("mid_reset_req_low", V_RST);
        rst = 1'b0;
        idle();
        cyc("mid_reset_run", V_NORM);
        cyc("mid_reset_idle", V_NORM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
